// File: rtl/raminfr_pkg.sv
// Shared geometry defaults and word/address types for the raminfr scratch RAM.
package raminfr_pkg;
    localparam int RAMINFR_ADDR_W = 5;
    localparam int RAMINFR_DATA_W = 4;

    typedef logic [RAMINFR_ADDR_W-1:0] raminfr_addr_t;
    typedef logic [RAMINFR_DATA_W-1:0] raminfr_data_t;
endpackage

// File: rtl/raminfr.sv
// Dual-port distributed RAM: port A synchronous write plus async read, port B async read.
// A synchronous reset clears every word in a single edge.
module raminfr
    import raminfr_pkg::*;
#(
    parameter int ADDR_W = RAMINFR_ADDR_W,
    parameter int DATA_W = RAMINFR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [ADDR_W-1:0] dpra,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] spo,
    output logic [DATA_W-1:0] dpo
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset wins over a write in the same cycle; the clear is the only non-LUT-RAM behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[a] <= di;
        end
    end

    assign spo = mem_q[a];
    assign dpo = mem_q[dpra];
endmodule

// File: tb/tb_raminfr.sv
// Directed self-checking bench for raminfr: reset clear, dual async reads,
// write enable, read-during-write timing and reset priority.
module tb_raminfr;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we  = 1'b0;
    logic [4:0] a    = '0;
    logic [4:0] dpra = '0;
    logic [3:0] di   = '0;
    logic [3:0] spo;
    logic [3:0] dpo;

    int n_pass = 0;
    int n_total = 0;

    raminfr dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .a    (a),
        .dpra (dpra),
        .di   (di),
        .spo  (spo),
        .dpo  (dpo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        // Reset clears everything in one edge.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a    = 5'(i);
            dpra = 5'(31 - i);
            #1;
            check($sformatf("reset_spo[%0d]", i), spo, 4'b0000);
            check($sformatf("reset_dpo[%0d]", 31 - i), dpo, 4'b0000);
        end

        // Write two words, then read both ports with no further clock.
        we = 1'b1; a = 5'd1; di = 4'b1010;
        tick();
        a = 5'd2; di = 4'b1100;
        tick();
        we = 1'b0; a = 5'd1; dpra = 5'd2;
        #1;
        check("dual_spo_a1", spo, 4'b1010);
        check("dual_dpo_a2", dpo, 4'b1100);

        // Port B follows its address between edges.
        #2;
        dpra = 5'd1;
        #1;
        check("async_dpo_a1", dpo, 4'b1010);
        a = 5'd2;
        #1;
        check("async_spo_a2", spo, 4'b1100);

        // Write disabled: address 3 keeps its cleared value.
        we = 1'b0; a = 5'd3; di = 4'b1111;
        tick();
        tick();
        dpra = 5'd3;
        #1;
        check("wdis_spo_a3", spo, 4'b0000);
        check("wdis_dpo_a3", dpo, 4'b0000);

        // Read-during-write: old data before the edge, new data right after.
        a = 5'd5; dpra = 5'd5; we = 1'b1; di = 4'b0110;
        #1;
        check("rdw_pre_spo", spo, 4'b0000);
        check("rdw_pre_dpo", dpo, 4'b0000);
        tick();
        check("rdw_post_spo", spo, 4'b0110);
        check("rdw_post_dpo", dpo, 4'b0110);
        we = 1'b0;

        // Top address boundary write.
        we = 1'b1; a = 5'd31; di = 4'b0101;
        tick();
        we = 1'b0; dpra = 5'd31; a = 5'd0;
        #1;
        check("top_dpo_a31", dpo, 4'b0101);
        check("top_spo_a0", spo, 4'b0000);

        // Reset has priority over a simultaneous write and clears earlier data.
        rst = 1'b1; we = 1'b1; a = 5'd7; di = 4'b1001;
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        check("rprio_spo_a7", spo, 4'b0000);
        dpra = 5'd1;
        #1;
        check("rprio_dpo_a1", dpo, 4'b0000);
        a = 5'd2; dpra = 5'd5;
        #1;
        check("rprio_spo_a2", spo, 4'b0000);
        check("rprio_dpo_a5", dpo, 4'b0000);
        a = 5'd31;
        #1;
        check("rprio_spo_a31", spo, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
